// File: rtl/gate_test_pkg.sv
// Shared definitions for the gate-unit self-test controller: op encodings,
// FSM states and pass geometry.
package gate_test_pkg;

    typedef enum logic [2:0] {
        OP_OR_NAND   = 3'd0,
        OP_OR_NOR    = 3'd1,
        OP_AND_NAND  = 3'd2,
        OP_AND_NOR   = 3'd3,
        OP_XOR_NAND  = 3'd4,
        OP_XNOR_NOR  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    localparam int         NUM_OPS  = 6;
    localparam int         NUM_VEC  = 4;
    localparam logic [3:0] ERR_MAX  = 4'd15;
    localparam logic [2:0] LAST_OP  = 3'(NUM_OPS - 1);
    localparam logic [1:0] LAST_VEC = 2'(NUM_VEC - 1);

endpackage

// File: rtl/gate_expected.sv
// Reference truth table for each gate unit: the logic function a correctly
// built NAND/NOR network must produce for the selected op.
module gate_expected
    import gate_test_pkg::*;
(
    input  logic [2:0] i_op,
    input  logic       i_x,
    input  logic       i_y,
    output logic       o_expected
);

    // NOTE: assign a default before the case so no path leaves the output unassigned (no latch).
    always_comb begin
        o_expected = 1'b0;
        case (op_e'(i_op))
            OP_OR_NAND, OP_OR_NOR:   o_expected = i_x | i_y;
            OP_AND_NAND, OP_AND_NOR: o_expected = i_x & i_y;
            OP_XOR_NAND:             o_expected = i_x ^ i_y;
            OP_XNOR_NOR:             o_expected = ~(i_x ^ i_y);
            default:                 o_expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_selftest_ctrl.sv
// Self-test sequencer: walks every op over all four operand vectors, compares
// the gate unit's answer with the reference and records mismatches.
module gate_selftest_ctrl
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic [2:0] op_o,
    output logic       x_o,
    output logic       y_o,
    input  logic       dut_s_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] fail_op,
    output logic [1:0] fail_vec
);

    state_e     r_state;
    state_e     w_next_state;
    logic [2:0] r_settle;
    logic [2:0] r_op;
    logic [1:0] r_vec;
    logic [3:0] r_err;
    logic [2:0] r_fail_op;
    logic [1:0] r_fail_vec;
    logic       r_pass;

    logic       w_expected;
    logic       w_active;
    logic       w_accept;
    logic       w_settled;
    logic       w_commit;
    logic       w_mismatch;
    logic       w_last_vec;
    logic       w_last_op;
    logic [3:0] w_err_next;

    gate_expected u_expected (
        .i_op       (r_op),
        .i_x        (r_vec[1]),
        .i_y        (r_vec[0]),
        .o_expected (w_expected)
    );

    assign w_active   = (r_state == ST_APPLY) || (r_state == ST_SAMPLE);
    assign w_accept   = (r_state == ST_IDLE) && start && !abort;
    assign w_settled  = (r_settle == 3'(SETTLE_CYC - 1));
    assign w_commit   = (r_state == ST_SAMPLE) && !abort;
    assign w_mismatch = (dut_s_i != w_expected);
    assign w_last_vec = (r_vec == LAST_VEC);
    assign w_last_op  = (r_op == LAST_OP);
    assign w_err_next = (w_mismatch && (r_err != ERR_MAX)) ? r_err + 4'd1 : r_err;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_next_state = ST_APPLY;
            ST_APPLY: begin
                if (abort)          w_next_state = ST_IDLE;
                else if (w_settled) w_next_state = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort)                        w_next_state = ST_IDLE;
                else if (w_last_vec && w_last_op) w_next_state = ST_DONE;
                else                              w_next_state = ST_APPLY;
            end
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle   <= '0;
            r_op       <= '0;
            r_vec      <= '0;
            r_err      <= '0;
            r_fail_op  <= '0;
            r_fail_vec <= '0;
            r_pass     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_settle   <= '0;
                r_op       <= '0;
                r_vec      <= '0;
                r_err      <= '0;
                r_fail_op  <= '0;
                r_fail_vec <= '0;
                r_pass     <= 1'b0;
            end

            if (r_state == ST_APPLY)
                r_settle <= (abort || w_settled) ? 3'd0 : r_settle + 3'd1;

            // An aborted sample leaves the result fields untouched.
            if (w_commit) begin
                r_err <= w_err_next;
                if (w_mismatch && (r_err == 4'd0)) begin
                    r_fail_op  <= r_op;
                    r_fail_vec <= r_vec;
                end
                if (!w_last_vec) begin
                    r_vec <= r_vec + 2'd1;
                end else begin
                    r_vec <= '0;
                    r_op  <= w_last_op ? 3'd0 : r_op + 3'd1;
                end
                if (w_last_vec && w_last_op)
                    r_pass <= (w_err_next == 4'd0);
            end
        end
    end

    assign op_o      = w_active ? r_op : 3'd0;
    assign x_o       = w_active & r_vec[1];
    assign y_o       = w_active & r_vec[0];
    assign busy      = w_active;
    assign done      = (r_state == ST_DONE);
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_op   = r_fail_op;
    assign fail_vec  = r_fail_vec;

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Directed bench for gate_selftest_ctrl: clean, faulty, aborted and reset
// passes at SETTLE_CYC=1, plus a SETTLE_CYC=3 pass with a redundant start.
module tb_gate_selftest_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       start3 = 1'b0;
    logic [2:0] op_o, op3;
    logic       x_o, y_o, x3, y3;
    logic       dut_s, dut_s3;
    logic       busy, done, pass, busy3, done3, pass3;
    logic [3:0] err, err3;
    logic [2:0] fop, fop3;
    logic [1:0] fvec, fvec3;

    int mode = 0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // Gate-unit model: 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 inverted.
    function automatic logic gate_model(input int m, input logic [2:0] op, input logic x, input logic y);
        logic g;
        case (op)
            3'd0, 3'd1: g = x | y;
            3'd2, 3'd3: g = x & y;
            3'd4:       g = x ^ y;
            3'd5:       g = ~(x ^ y);
            default:    g = 1'b0;
        endcase
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~g;
            default: return g;
        endcase
    endfunction

    assign dut_s  = gate_model(mode, op_o, x_o, y_o);
    assign dut_s3 = gate_model(0, op3, x3, y3);

    gate_selftest_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .op_o(op_o), .x_o(x_o), .y_o(y_o), .dut_s_i(dut_s),
        .busy(busy), .done(done), .pass(pass), .err_count(err),
        .fail_op(fop), .fail_vec(fvec)
    );

    gate_selftest_ctrl #(.SETTLE_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(1'b0),
        .op_o(op3), .x_o(x3), .y_o(y3), .dut_s_i(dut_s3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_op(fop3), .fail_vec(fvec3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // All outputs of the default instance packed for one comparison.
    function automatic logic [31:0] all_outs();
        return {17'd0, op_o, x_o, y_o, busy, done, pass, err, fop, fvec};
    endfunction

    task automatic run_pass(input int m, input int exp_err, input int exp_fop,
                            input int exp_fvec, input int exp_pass, input string tag);
        int cyc;
        bit seen;
        mode  = m;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc   = 0;
        seen  = 1'b0;
        while (!seen && cyc < 200) begin
            step();
            cyc++;
            if (done) seen = 1'b1;
        end
        check({tag, "_len"}, cyc, 48);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pass"}, pass, exp_pass);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_fop"}, fop, exp_fop);
        check({tag, "_fvec"}, fvec, exp_fvec);
        step();
        check({tag, "_done_off"}, done, 0);
        check({tag, "_hold"}, {pass, err, fop, fvec}, {exp_pass[0], exp_err[3:0], exp_fop[2:0], exp_fvec[1:0]});
    endtask

    task automatic watch_no_done(input string tag);
        int dones;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (done) dones++;
        end
        check(tag, dones, 0);
    endtask

    initial begin
        int dones;
        int first;

        // Reset state, then start on the first edge after release.
        #1;
        check("reset_outs", all_outs(), 0);
        step();
        step();
        check("reset_hold", all_outs(), 0);
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int op = 0; op < 6; op++) begin
            for (int v = 0; v < 4; v++) begin
                check($sformatf("apply_%0d_%0d", op, v), {busy, op_o, x_o, y_o}, {1'b1, 3'(op), 2'(v)});
                step();
                check($sformatf("sample_%0d_%0d", op, v), {busy, op_o, x_o, y_o}, {1'b1, 3'(op), 2'(v)});
                step();
            end
        end
        check("clean_done", done, 1);
        check("clean_busy", busy, 0);
        check("clean_pass", pass, 1);
        check("clean_err", err, 0);
        check("clean_ops_idle", {op_o, x_o, y_o}, 0);
        step();
        check("clean_done_off", done, 0);

        // Start together with abort in IDLE is ignored.
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_ignored", busy, 0);

        run_pass(1, 12, 0, 1, 0, "stuck0");
        run_pass(2, 12, 0, 0, 0, "stuck1");
        run_pass(3, 15, 0, 0, 0, "invert");

        // Abort in APPLY ten cycles in: five vectors scored, three mismatches.
        mode  = 1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("abort_busy_before", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_pass", pass, 0);
        check("abort_err", err, 3);
        check("abort_fail", {fop, fvec}, {3'd0, 2'd1});
        watch_no_done("abort_no_done");
        check("abort_hold", err, 3);

        // Abort coinciding with SAMPLE of op1/01 must not score it.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 11; i++) step();
        check("abort_s_state", {busy, op_o, x_o, y_o}, {1'b1, 3'd1, 2'd1});
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_s_busy", busy, 0);
        check("abort_s_err", err, 3);
        run_pass(0, 0, 0, 0, 1, "after_abort");

        // Reset during op 3 with stuck-at-1: partial count then full clear.
        mode  = 2;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 24; i++) step();
        check("rst_mid_op", op_o, 3);
        check("rst_mid_err", err, 5);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", all_outs(), 0);
        step();
        step();
        rst_n = 1'b1;
        watch_no_done("rst_no_done");
        run_pass(0, 0, 0, 0, 1, "after_rst");

        // SETTLE_CYC=3 with a second start while busy.
        start3 = 1'b1;
        step();
        dones = 0;
        first = 0;
        for (int i = 1; i <= 200; i++) begin
            start3 = (i == 5);
            step();
            if (done3) begin
                dones++;
                if (first == 0) first = i;
            end
        end
        start3 = 1'b0;
        check("settle3_len", first, 96);
        check("settle3_dones", dones, 1);
        check("settle3_pass", pass3, 1);
        check("settle3_err", err3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
